// File: rtl/frame_draw_sequencer.sv
// Sequences one full 160x120 frame redraw per request over the single VGA pixel-write port:
// a raster pass (background plus border walls), then the apple pixel, then each snake segment.
module frame_draw_sequencer #(
  parameter int unsigned H_RES        = 160,
  parameter int unsigned V_RES        = 120,
  parameter int unsigned WALL_W       = 2,
  parameter int unsigned MAX_SEGS     = 128,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  WALL_COLOUR  = 3'b001,
  parameter logic [2:0]  APPLE_COLOUR = 3'b100,
  parameter logic [2:0]  SNAKE_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       stall,
  input  logic [7:0] apple_x,
  input  logic [6:0] apple_y,
  input  logic [7:0] snake_size,
  output logic [7:0] seg_idx,
  input  logic [7:0] seg_x,
  input  logic [6:0] seg_y,
  output logic       plot,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] XRes    = 8'(H_RES);
  localparam logic [7:0] XLast   = 8'(H_RES - 1);
  localparam logic [7:0] XWallLo = 8'(WALL_W);
  localparam logic [7:0] XWallHi = 8'(H_RES - WALL_W);
  localparam logic [6:0] YRes    = 7'(V_RES);
  localparam logic [6:0] YLast   = 7'(V_RES - 1);
  localparam logic [6:0] YWallLo = 7'(WALL_W);
  localparam logic [6:0] YWallHi = 7'(V_RES - WALL_W);
  localparam logic [7:0] NszMax  = 8'(MAX_SEGS);

  typedef enum logic [2:0] {StIdle, StRaster, StApple, StSnake, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] rx_q, rx_d;
  logic [6:0] ry_q, ry_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] ax_q, ax_d;
  logic [6:0] ay_q, ay_d;
  logic [7:0] nsz_q, nsz_d;

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    seg_d   = seg_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    nsz_d   = nsz_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StRaster;
          rx_d    = '0;
          ry_d    = '0;
          seg_d   = '0;
          ax_d    = apple_x;
          ay_d    = apple_y;
          nsz_d   = (snake_size > NszMax) ? NszMax : snake_size;
        end
      end
      StRaster: begin
        if (!stall) begin
          if (rx_q == XLast) begin
            rx_d = '0;
            if (ry_q == YLast) begin
              ry_d    = '0;
              state_d = StApple;
            end else begin
              ry_d = ry_q + 7'd1;
            end
          end else begin
            rx_d = rx_q + 8'd1;
          end
        end
      end
      StApple: begin
        if (!stall) begin
          seg_d   = '0;
          state_d = (nsz_q != 8'd0) ? StSnake : StDone;
        end
      end
      StSnake: begin
        if (!stall) begin
          if (seg_q == nsz_q - 8'd1) begin
            seg_d   = '0;
            state_d = StDone;
          end else begin
            seg_d = seg_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rx_q    <= '0;
      ry_q    <= '0;
      seg_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      nsz_q   <= '0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      seg_q   <= seg_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      nsz_q   <= nsz_d;
    end
  end

  // Pixel outputs decode straight from registered state; off-screen apple/segments never plot.
  always_comb begin
    plot       = 1'b0;
    draw_x     = '0;
    draw_y     = '0;
    colour     = BG_COLOUR;
    seg_idx    = '0;
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
    unique case (state_q)
      StRaster: begin
        plot   = !stall;
        draw_x = rx_q;
        draw_y = ry_q;
        if (rx_q < XWallLo || rx_q >= XWallHi || ry_q < YWallLo || ry_q >= YWallHi) begin
          colour = WALL_COLOUR;
        end
      end
      StApple: begin
        plot   = !stall && (ax_q < XRes) && (ay_q < YRes);
        draw_x = ax_q;
        draw_y = ay_q;
        colour = APPLE_COLOUR;
      end
      StSnake: begin
        seg_idx = seg_q;
        plot    = !stall && (seg_x < XRes) && (seg_y < YRes);
        draw_x  = seg_x;
        draw_y  = seg_y;
        colour  = SNAKE_COLOUR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Drives randomized frames into frame_draw_sequencer and compares every cycle against an
// expected pixel stream built from the drawing rules (raster, apple, snake, done).
module tb_frame_draw_sequencer;

  localparam int HRes = 160;
  localparam int VRes = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] apple_x = '0;
  logic [6:0] apple_y = '0;
  logic [7:0] snake_size = '0;
  logic [7:0] seg_idx;
  logic [7:0] seg_x;
  logic [6:0] seg_y;
  logic       plot;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic [2:0] colour;
  logic       busy;
  logic       frame_done;

  logic [7:0] sx_mem [256];
  logic [6:0] sy_mem [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic [7:0] seg;
    bit         done;
    bit         raster;
  } px_t;

  px_t q[$];

  frame_draw_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .stall      (stall),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .snake_size (snake_size),
    .seg_idx    (seg_idx),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .plot       (plot),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .colour     (colour),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Segment table behaves as a combinational same-cycle lookup.
  assign seg_x = sx_mem[seg_idx];
  assign seg_y = sy_mem[seg_idx];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_plot"}, 32'(plot), 0);
    check_eq({tag, "_done"}, 32'(frame_done), 0);
    check_eq({tag, "_x"}, 32'(draw_x), 0);
    check_eq({tag, "_y"}, 32'(draw_y), 0);
    check_eq({tag, "_col"}, 32'(colour), 0);
    check_eq({tag, "_seg"}, 32'(seg_idx), 0);
  endtask

  function automatic void build_frame(input logic [7:0] ax, input logic [6:0] ay, input int nsz);
    px_t p;
    q.delete();
    for (int y = 0; y < VRes; y++) begin
      for (int x = 0; x < HRes; x++) begin
        p.plot   = 1'b1;
        p.x      = 8'(x);
        p.y      = 7'(y);
        p.col    = (x < 2 || x >= HRes - 2 || y < 2 || y >= VRes - 2) ? 3'b001 : 3'b000;
        p.seg    = 8'd0;
        p.done   = 1'b0;
        p.raster = 1'b1;
        q.push_back(p);
      end
    end
    p.raster = 1'b0;
    p.plot   = (int'(ax) < HRes) && (int'(ay) < VRes);
    p.x      = ax;
    p.y      = ay;
    p.col    = 3'b100;
    q.push_back(p);
    for (int k = 0; k < nsz; k++) begin
      p.plot = (int'(sx_mem[k]) < HRes) && (int'(sy_mem[k]) < VRes);
      p.x    = sx_mem[k];
      p.y    = sy_mem[k];
      p.col  = 3'b111;
      p.seg  = 8'(k);
      q.push_back(p);
    end
    p.plot = 1'b0;
    p.seg  = 8'd0;
    p.done = 1'b1;
    q.push_back(p);
  endfunction

  // Entry: #1 after a posedge with the DUT idle. reset_seg >= 0 aborts the frame by reset there.
  task automatic run_frame(input string tag, input logic [7:0] ax, input logic [6:0] ay,
                           input logic [7:0] sz, input bit rnd_stall, input bit poke,
                           input int reset_seg);
    int  nsz;
    int  lat = 0;
    int  done_lat = -1;
    int  nstall = 0;
    int  rplots = 0;
    int  idx = 0;
    int  burst = 0;
    bit  burst_done = 1'b0;
    bit  aborted = 1'b0;
    px_t it;
    nsz = (int'(sz) > 128) ? 128 : int'(sz);
    build_frame(ax, ay, nsz);
    apple_x = ax;
    apple_y = ay;
    snake_size = sz;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    apple_x = 8'($urandom);
    apple_y = 7'($urandom);
    snake_size = 8'($urandom);
    check_eq({tag, "_busy_after_start"}, 32'(busy), 1);
    while (q.size() > 0) begin
      it = q[0];
      stall = 1'b0;
      frame_start = 1'b0;
      if (rnd_stall) begin
        if (!burst_done && idx == 3 * HRes + 10) begin
          burst = 5;
          burst_done = 1'b1;
        end
        if (burst > 0) begin
          stall = 1'b1;
          burst--;
        end else begin
          stall = ($urandom_range(15) == 0);
        end
      end
      if (poke) frame_start = it.done ? 1'b1 : ($urandom_range(63) == 0);
      #1;
      if (stall && !it.done) begin
        check_eq({tag, "_stall_plot"}, 32'(plot), 0);
        nstall++;
      end else begin
        check_eq({tag, "_plot"}, 32'(plot), 32'(it.plot));
        if (it.raster && plot) rplots++;
      end
      check_eq({tag, "_busy"}, 32'(busy), 1);
      check_eq({tag, "_done"}, 32'(frame_done), 32'(it.done));
      check_eq({tag, "_seg_idx"}, 32'(seg_idx), 32'(it.seg));
      if (!it.done) begin
        check_eq({tag, "_x"}, 32'(draw_x), 32'(it.x));
        check_eq({tag, "_y"}, 32'(draw_y), 32'(it.y));
        check_eq({tag, "_col"}, 32'(colour), 32'(it.col));
      end
      if (frame_done && done_lat < 0) done_lat = lat;
      if (reset_seg >= 0 && !it.raster && !it.done && it.col == 3'b111 &&
          int'(it.seg) == reset_seg) begin
        reset = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
      idx++;
      if (aborted) begin
        reset = 1'b0;
        q.delete();
      end else if (!stall || it.done) begin
        void'(q.pop_front());
      end else begin
        idx--;
      end
    end
    stall = 1'b0;
    frame_start = 1'b0;
    #1;
    check_idle({tag, "_idle0"});
    @(posedge clk);
    #1;
    check_idle({tag, "_idle1"});
    if (!aborted) begin
      check_eq({tag, "_raster_plots"}, 32'(rplots), 32'(HRes * VRes));
      check_eq({tag, "_latency"}, 32'(done_lat), 32'(HRes * VRes + 1 + nsz + nstall));
    end else begin
      check_eq({tag, "_no_done_after_reset"}, 32'(done_lat), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sx_mem[i] = 8'($urandom_range(0, 175));
      sy_mem[i] = 7'($urandom_range(0, 127));
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_idle("reset");
    @(posedge clk);
    #1;
    check_idle("idle_hold");

    // Directed: apple (50,50), three adjacent segments, no stall.
    sx_mem[0] = 8'd30;
    sx_mem[1] = 8'd31;
    sx_mem[2] = 8'd32;
    sy_mem[0] = 7'd20;
    sy_mem[1] = 7'd20;
    sy_mem[2] = 7'd20;
    run_frame("directed", 8'd50, 7'd50, 8'd3, 1'b0, 1'b0, -1);

    // Off-screen apple, size clamped to 128, stalls (including a 5-cycle burst at (10,3)),
    // frame_start pokes while busy and during DONE.
    for (int i = 0; i < 128; i++) begin
      sx_mem[i] = 8'($urandom_range(0, 175));
      sy_mem[i] = 7'($urandom_range(0, 127));
    end
    run_frame("clamp_stall", 8'd200, 7'($urandom_range(0, 119)), 8'd200, 1'b1, 1'b1, -1);

    // Reset during the snake pass abandons the frame.
    run_frame("reset_mid", 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 8'd5,
              1'b0, 1'b0, 2);

    // Empty snake: APPLE goes straight to DONE.
    run_frame("empty", 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 8'd0,
              1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
